time_report_sched: RTL and testbench

- Scheduler that sequences ASCII report frames into the serial UART transmitter so the board drives `txd`.
- Two requesters share the one transmitter:
  - periodic time report, triggered by seconds changes;
  - alarm event report.
- Sits between the BCD time bus (dhour/dmin/dsec) and the UART TX byte engine. It owns the TX byte handshake.

---
 rtl/clock_pkg.sv | 41 ++++
 rtl/time_report_sched_if.sv | 9 +
 rtl/report_byte_mux.sv | 66 ++++++
 rtl/time_report_sched.sv | 177 +++++++++++++++++
 tb/tb_time_report_sched.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared FSM encoding, ASCII constants and frame lengths for the report scheduler.
// Frame lengths grow by two checksum characters when REPORT_CKSUM_EN is defined.
package clock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_REQ,
        ST_ACK,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef enum logic {
        SEL_TIME,
        SEL_ALARM
    } frame_sel_e;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] COLON   = 8'h3A;
    localparam logic [7:0] QMARK   = 8'h3F;
    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] LF      = 8'h0A;

`ifdef REPORT_CKSUM_EN
    localparam int unsigned TIME_LEN = 12;
    localparam int unsigned ALM_LEN  = 9;
`else
    localparam int unsigned TIME_LEN = 10;
    localparam int unsigned ALM_LEN  = 7;
`endif

    localparam int unsigned TIME_PAYLOAD = 8;
    localparam int unsigned ALM_PAYLOAD  = 5;

    localparam logic [3:0] TIME_LAST   = 4'(TIME_LEN - 1);
    localparam logic [3:0] ALM_LAST    = 4'(ALM_LEN - 1);
    localparam logic [3:0] TIME_CR_IDX = 4'(TIME_LEN - 2);
    localparam logic [3:0] ALM_CR_IDX  = 4'(ALM_LEN - 2);

endpackage

// File: rtl/time_report_sched_if.sv
// UART TX byte handshake between the report scheduler (master) and the transmitter (slave).
interface time_report_sched_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (output tx_start, output tx_data, input tx_busy);
    modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/report_byte_mux.sv
// Combinational frame byte selector: (frame, index, snapshot, checksum) -> ASCII byte.
// The checksum input and hex characters exist only when REPORT_CKSUM_EN is defined.
module report_byte_mux
    import clock_pkg::*;
(
    input  frame_sel_e  frame_sel,
    input  logic [3:0]  idx,
    input  logic [7:0]  snap_hour,
    input  logic [7:0]  snap_min,
    input  logic [7:0]  snap_sec,
`ifdef REPORT_CKSUM_EN
    input  logic [7:0]  cksum,
`endif
    output logic [7:0]  byte_out
);

    // Non-decimal nibbles print as '?' so corrupt BCD is visible on the terminal.
    function automatic logic [7:0] bcd_ascii(input logic [3:0] nib);
        return (nib > 4'd9) ? QMARK : (ASCII_0 + {4'h0, nib});
    endfunction

`ifdef REPORT_CKSUM_EN
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib > 4'd9) ? (8'h37 + {4'h0, nib}) : (ASCII_0 + {4'h0, nib});
    endfunction
`endif

    always_comb begin
        byte_out = '0;
        if (frame_sel == SEL_ALARM) begin
            case (idx)
                4'd0:       byte_out = 8'h41;  // "ALARM"
                4'd1:       byte_out = 8'h4C;
                4'd2:       byte_out = 8'h41;
                4'd3:       byte_out = 8'h52;
                4'd4:       byte_out = 8'h4D;
`ifdef REPORT_CKSUM_EN
                4'd5:       byte_out = hex_ascii(cksum[7:4]);
                4'd6:       byte_out = hex_ascii(cksum[3:0]);
`endif
                ALM_CR_IDX: byte_out = CR;
                ALM_LAST:   byte_out = LF;
                default:    byte_out = '0;
            endcase
        end else begin
            case (idx)
                4'd0:        byte_out = bcd_ascii(snap_hour[7:4]);
                4'd1:        byte_out = bcd_ascii(snap_hour[3:0]);
                4'd2:        byte_out = COLON;
                4'd3:        byte_out = bcd_ascii(snap_min[7:4]);
                4'd4:        byte_out = bcd_ascii(snap_min[3:0]);
                4'd5:        byte_out = COLON;
                4'd6:        byte_out = bcd_ascii(snap_sec[7:4]);
                4'd7:        byte_out = bcd_ascii(snap_sec[3:0]);
`ifdef REPORT_CKSUM_EN
                4'd8:        byte_out = hex_ascii(cksum[7:4]);
                4'd9:        byte_out = hex_ascii(cksum[3:0]);
`endif
                TIME_CR_IDX: byte_out = CR;
                TIME_LAST:   byte_out = LF;
                default:     byte_out = '0;
            endcase
        end
    end

endmodule

// File: rtl/time_report_sched.sv
// Sequences periodic time and alarm ASCII report frames into the UART TX byte engine.
// Optional REPORT_CKSUM_EN appends an XOR checksum (two hex chars) before CR LF.
module time_report_sched
    import clock_pkg::*;
#(
    parameter int unsigned PERIOD_S = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [7:0]                 dhour,
    input  logic [7:0]                 dmin,
    input  logic [7:0]                 dsec,
    input  logic                       alarm_evt,
    time_report_sched_if.master        tx,
    output logic                       frame_active,
    output logic [7:0]                 frames_sent
);

    state_e     state_q, state_d;
    frame_sel_e sel_q, sel_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] prev_sec_q, prev_sec_d;
    logic [5:0] per_cnt_q, per_cnt_d;
    logic       pend_time_q, pend_time_d;
    logic       pend_alm_q, pend_alm_d;
    logic [7:0] snap_hour_q, snap_hour_d;
    logic [7:0] snap_min_q, snap_min_d;
    logic [7:0] snap_sec_q, snap_sec_d;
    logic [7:0] frames_sent_q, frames_sent_d;
    logic [7:0] mux_byte;
    logic [3:0] frame_last;
`ifdef REPORT_CKSUM_EN
    logic [7:0] cksum_q, cksum_d;
    logic [3:0] payload_len;
`endif

    report_byte_mux u_mux (
        .frame_sel (sel_q),
        .idx       (idx_q),
        .snap_hour (snap_hour_q),
        .snap_min  (snap_min_q),
        .snap_sec  (snap_sec_q),
`ifdef REPORT_CKSUM_EN
        .cksum     (cksum_q),
`endif
        .byte_out  (mux_byte)
    );

    assign frame_last = (sel_q == SEL_ALARM) ? ALM_LAST : TIME_LAST;
`ifdef REPORT_CKSUM_EN
    assign payload_len = (sel_q == SEL_ALARM) ? 4'(ALM_PAYLOAD) : 4'(TIME_PAYLOAD);
`endif

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        idx_d         = idx_q;
        prev_sec_d    = dsec;
        per_cnt_d     = per_cnt_q;
        pend_time_d   = pend_time_q;
        pend_alm_d    = pend_alm_q;
        snap_hour_d   = snap_hour_q;
        snap_min_d    = snap_min_q;
        snap_sec_d    = snap_sec_q;
        frames_sent_d = frames_sent_q;
`ifdef REPORT_CKSUM_EN
        cksum_d       = cksum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (pend_alm_q) begin
                    sel_d   = SEL_ALARM;
                    state_d = ST_SNAP;
                end else if (pend_time_q) begin
                    sel_d   = SEL_TIME;
                    state_d = ST_SNAP;
                end
            end
            ST_SNAP: begin
                snap_hour_d = dhour;
                snap_min_d  = dmin;
                snap_sec_d  = dsec;
                idx_d       = '0;
                if (sel_q == SEL_ALARM) pend_alm_d = 1'b0;
                else                    pend_time_d = 1'b0;
`ifdef REPORT_CKSUM_EN
                cksum_d     = '0;
`endif
                state_d     = ST_REQ;
            end
            ST_REQ: begin
                if (tx.tx_busy) state_d = ST_ACK;
            end
            ST_ACK: begin
                if (!tx.tx_busy) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
`ifdef REPORT_CKSUM_EN
                if (idx_q < payload_len) cksum_d = cksum_q ^ mux_byte;
`endif
                if (idx_q == frame_last) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                frames_sent_d = frames_sent_q + 8'd1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // New requests are applied after the SNAP clear so a request arriving
        // in the snapshot cycle is kept for the next frame.
        if (!en) begin
            pend_time_d = 1'b0;
            pend_alm_d  = 1'b0;
            per_cnt_d   = '0;
        end else begin
            if (dsec != prev_sec_q) begin
                if (per_cnt_q == 6'(PERIOD_S - 1)) begin
                    per_cnt_d   = '0;
                    pend_time_d = 1'b1;
                end else begin
                    per_cnt_d   = per_cnt_q + 6'd1;
                end
            end
            if (alarm_evt) pend_alm_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            sel_q         <= SEL_TIME;
            idx_q         <= '0;
            prev_sec_q    <= 8'h00;
            per_cnt_q     <= '0;
            pend_time_q   <= 1'b0;
            pend_alm_q    <= 1'b0;
            snap_hour_q   <= '0;
            snap_min_q    <= '0;
            snap_sec_q    <= '0;
            frames_sent_q <= '0;
`ifdef REPORT_CKSUM_EN
            cksum_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            idx_q         <= idx_d;
            prev_sec_q    <= prev_sec_d;
            per_cnt_q     <= per_cnt_d;
            pend_time_q   <= pend_time_d;
            pend_alm_q    <= pend_alm_d;
            snap_hour_q   <= snap_hour_d;
            snap_min_q    <= snap_min_d;
            snap_sec_q    <= snap_sec_d;
            frames_sent_q <= frames_sent_d;
`ifdef REPORT_CKSUM_EN
            cksum_q       <= cksum_d;
`endif
        end
    end

    // Outputs decode the state register so an async reset drops tx_start at once.
    assign tx.tx_start  = (state_q == ST_REQ);
    assign tx.tx_data   = (state_q == ST_REQ) ? mux_byte : '0;
    assign frame_active = (state_q == ST_SNAP) || (state_q == ST_REQ) ||
                          (state_q == ST_ACK)  || (state_q == ST_DRAIN);
    assign frames_sent  = frames_sent_q;

endmodule

// File: tb/tb_time_report_sched.sv
// Self-checking bench for time_report_sched: UART responder plus a frame-text reference model.
// Expected frames include checksum characters when REPORT_CKSUM_EN is defined.
module tb_time_report_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] dhour, dmin, dsec;
    logic       alarm_evt;
    logic       frame_active;
    logic [7:0] frames_sent;

    time_report_sched_if tb_if ();

    time_report_sched #(.PERIOD_S(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .dhour        (dhour),
        .dmin         (dmin),
        .dsec         (dsec),
        .alarm_evt    (alarm_evt),
        .tx           (tb_if),
        .frame_active (frame_active),
        .frames_sent  (frames_sent)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int exp_frames = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    // UART responder: accepts a byte when idle, then stays busy for a while.
    int ub_cnt = 0;
    bit busy_rand = 1'b0;
    always @(posedge clk) begin
        if (ub_cnt != 0) begin
            ub_cnt <= ub_cnt - 1;
        end else if (tb_if.tx_start === 1'b1) begin
            got.push_back(tb_if.tx_data);
            ub_cnt <= busy_rand ? int'($urandom_range(1, 6)) : 5;
        end
    end
    assign tb_if.tx_busy = (ub_cnt != 0);

    function automatic logic [7:0] nib_ascii(input logic [3:0] n);
        return (n > 4'd9) ? 8'h3F : (8'h30 + 8'(n));
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n > 4'd9) ? (8'h41 + 8'(n) - 8'd10) : (8'h30 + 8'(n));
    endfunction

    function automatic void close_frame(input int start);
`ifdef REPORT_CKSUM_EN
        logic [7:0] x = 8'h00;
        for (int i = start; i < exp_q.size(); i++) x = x ^ exp_q[i];
        exp_q.push_back(hex_ascii(x[7:4]));
        exp_q.push_back(hex_ascii(x[3:0]));
`else
        if (start < 0) exp_q.push_back(8'h00);
`endif
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    function automatic void exp_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        int st = exp_q.size();
        exp_q.push_back(nib_ascii(h[7:4])); exp_q.push_back(nib_ascii(h[3:0]));
        exp_q.push_back(8'h3A);
        exp_q.push_back(nib_ascii(m[7:4])); exp_q.push_back(nib_ascii(m[3:0]));
        exp_q.push_back(8'h3A);
        exp_q.push_back(nib_ascii(s[7:4])); exp_q.push_back(nib_ascii(s[3:0]));
        close_frame(st);
    endfunction

    function automatic void exp_alarm();
        string txt = "ALARM";
        int st = exp_q.size();
        for (int i = 0; i < txt.len(); i++) exp_q.push_back(txt[i]);
        close_frame(st);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target);
        int k = 0;
        while (frames_sent !== 8'(target) && k < 3000) begin
            tick(1);
            k++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; alarm_evt = 1'b0;
        dhour = 8'h00; dmin = 8'h00; dsec = 8'h00;
        tick(3);
        total++; if (tb_if.tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b exp=0", tb_if.tx_start); end
        total++; if (tb_if.tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tb_if.tx_data); end
        total++; if (frame_active !== 1'b0) begin bad++; $display("FAIL reset_frame_active got=%b exp=0", frame_active); end
        total++; if (frames_sent !== 8'h00) begin bad++; $display("FAIL reset_frames_sent got=%h exp=00", frames_sent); end
        reset = 1'b1;
        tick(3);
        total++; if (tb_if.tx_start !== 1'b0) begin bad++; $display("FAIL post_reset_idle got=%b exp=0", tb_if.tx_start); end
    endtask

    task automatic test_time_frame();
        dhour = 8'h12; dmin = 8'h34; dsec = 8'h07;
        tick(2);
        got.delete(); exp_q.delete();
        en = 1'b1;
        tick(4);
        total++; if (frame_active !== 1'b0) begin bad++; $display("FAIL no_change_no_frame got=%b exp=0", frame_active); end
        dsec = 8'h08;
        exp_time(8'h12, 8'h34, 8'h08);
        exp_frames++;
        wait_frames(exp_frames);
        total++; if (frames_sent !== 8'(exp_frames)) begin bad++; $display("FAIL time_frames_sent got=%0d exp=%0d", frames_sent, exp_frames); end
        total++; if (frame_active !== 1'b0) begin bad++; $display("FAIL time_frame_active_end got=%b exp=0", frame_active); end
        total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL time_len got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [7:0] g = (i < got.size()) ? got[i] : 8'hxx;
            total++; if (g !== exp_q[i]) begin bad++; $display("FAIL time_byte[%0d] got=%h exp=%h", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_alarm_priority();
        logic [7:0] s;
        got.delete(); exp_q.delete();
        dhour = 8'($urandom); dmin = 8'($urandom);
        s = dsec ^ 8'($urandom_range(1, 255));
        dsec = s; alarm_evt = 1'b1;
        tick(1);
        alarm_evt = 1'b0;
        exp_alarm();
        exp_time(dhour, dmin, s);
        exp_frames += 2;
        wait_frames(exp_frames);
        total++; if (frames_sent !== 8'(exp_frames)) begin bad++; $display("FAIL prio_frames_sent got=%0d exp=%0d", frames_sent, exp_frames); end
        total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL prio_len got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [7:0] g = (i < got.size()) ? got[i] : 8'hxx;
            total++; if (g !== exp_q[i]) begin bad++; $display("FAIL prio_byte[%0d] got=%h exp=%h", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_snapshot();
        int k = 0;
        got.delete(); exp_q.delete();
        dhour = 8'h12; dmin = 8'h45; dsec = 8'h20;
        exp_time(8'h12, 8'h45, 8'h20);
        while (got.size() < 1 && k < 500) begin tick(1); k++; end
        dhour = 8'h13; dsec = 8'h21;
        tick(3);
        dsec = 8'h22;
        tick(1);
        exp_time(8'h13, 8'h45, 8'h22);
        exp_frames += 2;
        wait_frames(exp_frames);
        tick(150);
        total++; if (frames_sent !== 8'(exp_frames)) begin bad++; $display("FAIL snap_frames_sent got=%0d exp=%0d", frames_sent, exp_frames); end
        total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL snap_len got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [7:0] g = (i < got.size()) ? got[i] : 8'hxx;
            total++; if (g !== exp_q[i]) begin bad++; $display("FAIL snap_byte[%0d] got=%h exp=%h", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_random_frames();
        busy_rand = 1'b1;
        for (int it = 0; it < 6; it++) begin
            logic [7:0] s;
            got.delete(); exp_q.delete();
            dhour = 8'($urandom);
            dmin  = (it == 0) ? 8'h3B : 8'($urandom);
            s = dsec ^ 8'($urandom_range(1, 255));
            dsec = s;
            exp_time(dhour, dmin, s);
            exp_frames++;
            wait_frames(exp_frames);
            tick(2);
            total++; if (frames_sent !== 8'(exp_frames)) begin bad++; $display("FAIL rand%0d_frames_sent got=%0d exp=%0d", it, frames_sent, exp_frames); end
            total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_len got=%0d exp=%0d", it, got.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                logic [7:0] g = (i < got.size()) ? got[i] : 8'hxx;
                total++; if (g !== exp_q[i]) begin bad++; $display("FAIL rand%0d_byte[%0d] got=%h exp=%h", it, i, g, exp_q[i]); end
            end
            if (it == 0) begin
                logic [7:0] g4 = (got.size() > 4) ? got[4] : 8'hxx;
                total++; if (g4 !== 8'h3F) begin bad++; $display("FAIL bad_nibble_byte4 got=%h exp=3f", g4); end
            end
        end
        busy_rand = 1'b0;
    endtask

    task automatic test_en_abort();
        int k = 0;
        got.delete(); exp_q.delete();
        dhour = 8'h08; dmin = 8'h15; dsec = 8'h42;
        exp_time(8'h08, 8'h15, 8'h42);
        while (got.size() < 2 && k < 500) begin tick(1); k++; end
        alarm_evt = 1'b1;
        tick(1);
        alarm_evt = 1'b0;
        tick(2);
        en = 1'b0;
        exp_frames++;
        wait_frames(exp_frames);
        tick(200);
        total++; if (frames_sent !== 8'(exp_frames)) begin bad++; $display("FAIL en_off_frames_sent got=%0d exp=%0d", frames_sent, exp_frames); end
        total++; if (frame_active !== 1'b0) begin bad++; $display("FAIL en_off_frame_active got=%b exp=0", frame_active); end
        total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL en_off_len got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [7:0] g = (i < got.size()) ? got[i] : 8'hxx;
            total++; if (g !== exp_q[i]) begin bad++; $display("FAIL en_off_byte[%0d] got=%h exp=%h", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int k = 0;
        int starts = 0;
        en = 1'b1;
        tick(2);
        dsec = dsec ^ 8'h01;
        while (tb_if.tx_start !== 1'b1 && k < 500) begin tick(1); k++; end
        total++; if (tb_if.tx_start !== 1'b1) begin bad++; $display("FAIL rst_reach_req got=%b exp=1", tb_if.tx_start); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (tb_if.tx_start !== 1'b0) begin bad++; $display("FAIL rst_async_tx_start got=%b exp=0", tb_if.tx_start); end
        total++; if (frame_active !== 1'b0) begin bad++; $display("FAIL rst_async_frame_active got=%b exp=0", frame_active); end
        total++; if (frames_sent !== 8'h00) begin bad++; $display("FAIL rst_async_frames_sent got=%0d exp=0", frames_sent); end
        en = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(3);
        en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick(1);
            if (tb_if.tx_start === 1'b1 || frame_active === 1'b1) starts++;
        end
        total++; if (starts != 0) begin bad++; $display("FAIL rst_idle_after_release got=%0d exp=0", starts); end
        total++; if (frames_sent !== 8'h00) begin bad++; $display("FAIL rst_frames_sent got=%0d exp=0", frames_sent); end
    endtask

    initial begin
        test_reset();
        test_time_frame();
        test_alarm_priority();
        test_snapshot();
        test_random_frames();
        test_en_abort();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
